a2d_rr_sched: RTL and testbench
===============================

// Module: a2d_rr_sched
// PURPOSE
//  Round-robin conversion scheduler for the Segway A2D path. On each nxt strobe it runs one
//  two-transaction SPI exchange for the next channel: command, then read-back. It drives the
//  shared SPI master, which serves one requester.
//  Results land in per-sensor holding registers (left/right load cell, steerPot, batt) that
//  feed the rider-detect, steering-enable and battery-monitor logic.
// PARAMETERS
//  GAP_CYCLES  2     idle cycles between the command and read transactions (1..15)
//  TMO_CYCLES  4096  max cycles waiting for done before abort (>=16)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   synchronous active-low reset
//  nxt        in   1   1-cycle strobe: start conversion of the current channel
//  done       in   1   SPI master transaction complete, 1-cycle pulse
//  rd_data    in   16  SPI read data; valid in the cycle done is high
//  wrt        out  1   1-cycle pulse: SPI master starts a transaction
//  cmd        out  16  SPI word, held stable from wrt until done
//  lft_ld     out  12  latest left load-cell result
//  rght_ld    out  12  latest right load-cell result
//  steer_pot  out  12  latest steering-pot result
//  batt       out  12  latest battery result
//  ch_vld     out  1   1-cycle pulse: a holding register was just updated
//  busy       out  1   high whenever state != IDLE
//  tmo_err    out  1   1-cycle pulse: transaction aborted on timeout
// BEHAVIOUR
//  Reset (rst_n low at posedge clk): state=IDLE, ptr=0, all outputs 0.
//   This includes all four holding registers; reset mid-transaction aborts it.
//  Channel map (ptr -> A2D ch -> register): 0->0 lft_ld, 1->4 rght_ld, 2->5 steer_pot,
//   3->6 batt. ptr is 2 bits and wraps 3->0.
//  Command word: cmd = {2'b00, ch[2:0], 11'h000}. Read word: cmd = 16'hDA00, a don't-care
//   payload the master shifts while reading.
//  FSM states: IDLE, CMD, WAIT1, GAP, READ, WAIT2, STORE.
//   IDLE : nxt=1 -> CMD. Otherwise stay.
//   CMD  : wrt=1 for one cycle, cmd=channel word -> WAIT1.
//   WAIT1: done=1 -> GAP. Result ignored.
//   GAP  : count GAP_CYCLES cycles -> READ.
//   READ : wrt=1 for one cycle, cmd=16'hDA00 -> WAIT2.
//   WAIT2: done=1 -> capture rd_data[11:0] -> STORE.
//   STORE: write the captured value to the register selected by ptr; ch_vld=1;
//          ptr<=ptr+1 -> IDLE.
//  Latency: nxt to ch_vld = 2 SPI transactions + GAP_CYCLES + 4 cycles.
//  Holding registers change only in STORE and keep their value otherwise; no partial
//   updates.
//  nxt while busy=1 is dropped, not queued. nxt in the same cycle as STORE is also
//   dropped, because busy is still high.
//  done in IDLE, CMD, GAP, READ or STORE is ignored.
//  Timeout: a counter clears on entry to WAIT1/WAIT2 and increments each cycle in them.
//   On reaching TMO_CYCLES-1 without done: tmo_err=1 for one cycle; the FSM goes to IDLE;
//   ptr advances; the register is unchanged; ch_vld stays 0.
//  done in the same cycle the counter hits TMO_CYCLES-1 counts as a success: capture,
//   no tmo_err.
//  wrt never asserts in two consecutive cycles. cmd changes only in the CMD and READ
//   cycles.
//  tmo_err and ch_vld are never high together.
// TESTING
//  1 Reset: hold rst_n=0 for 2 clk mid-WAIT2 -> next cycle IDLE, wrt=0, busy=0,
//    all registers 0, ptr=0.
//  2 Single conv: nxt; model returns 16'h0ABC on the 2nd done -> first cmd=16'h0000,
//    second cmd=16'hDA00, lft_ld=12'hABC, ch_vld pulses once.
//  3 Round robin: 5 nxt, each after ch_vld; reads 1,2,3,4,5 -> cmds ch0,4,5,6,0;
//    lft_ld=5, rght_ld=2, steer_pot=3, batt=4.
//  4 Dropped nxt: pulse nxt every cycle for 200 cycles with SPI latency 40 -> exactly one
//    wrt pair per conversion; no conversion restarts while busy.
//  5 Timeout: suppress done in WAIT1 -> tmo_err after TMO_CYCLES cycles; registers
//    unchanged; next nxt issues the next channel's cmd.
//  6 Edge done: done exactly at count TMO_CYCLES-1 in WAIT2 with 16'h0800 ->
//    steer_pot=12'h800, ch_vld=1, tmo_err=0.

Source files
------------

// File: rtl/a2d_rr_sched.sv
// rtl/a2d_rr_sched.sv - round-robin A2D conversion scheduler driving a shared SPI master
//
// Each nxt strobe runs one two-transaction SPI exchange for the channel selected
// by ptr: a command word, GAP_CYCLES idle cycles, then a read-back whose low
// 12 bits land in that channel's holding register.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   nxt             start a conversion of the current channel (ignored while busy)
//   done, rd_data   SPI master completion pulse and read data valid with it
//   wrt, cmd        SPI transaction start pulse and the word to send
//   lft_ld, rght_ld, steer_pot, batt   per-sensor holding registers
//   ch_vld          a holding register was just updated
//   busy            a conversion is in progress
//   tmo_err         a transaction was abandoned because done never arrived
module a2d_rr_sched #(
    parameter int GAP_CYCLES = 2,
    parameter int TMO_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        ch_vld,
    output logic        busy,
    output logic        tmo_err
);

    localparam int CW = $clog2(TMO_CYCLES);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [15:0]   RD_WORD  = 16'hDA00;

    typedef enum logic [2:0] {
        IDLE, CMD, WAIT1, GAP, READ, WAIT2, STORE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   cap_q, cap_d;
    logic [11:0]   lft_q, lft_d;
    logic [11:0]   rght_q, rght_d;
    logic [11:0]   steer_q, steer_d;
    logic [11:0]   batt_q, batt_d;
    logic          wrt_q, wrt_d;
    logic [15:0]   cmd_q, cmd_d;
    logic          ch_vld_q, ch_vld_d;
    logic          busy_q, busy_d;
    logic          tmo_err_q, tmo_err_d;

    // Only the 12-bit conversion result is meaningful in the read word.
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:12];

    function automatic logic [2:0] ch_map(input logic [1:0] p);
        case (p)
            2'd0:    ch_map = 3'd0;
            2'd1:    ch_map = 3'd4;
            2'd2:    ch_map = 3'd5;
            default: ch_map = 3'd6;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        lft_d     = lft_q;
        rght_d    = rght_q;
        steer_d   = steer_q;
        batt_d    = batt_q;
        wrt_d     = 1'b0;
        cmd_d     = cmd_q;
        ch_vld_d  = 1'b0;
        tmo_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (nxt) begin
                    // wrt/cmd are registered, so they are presented during the CMD cycle.
                    state_d = CMD;
                    wrt_d   = 1'b1;
                    cmd_d   = {2'b00, ch_map(ptr_q), 11'h000};
                end
            end
            CMD: begin
                state_d = WAIT1;
                cnt_d   = '0;
            end
            WAIT1: begin
                // done wins over a timeout landing in the same cycle.
                if (done) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = IDLE;
                    ptr_d     = ptr_q + 2'd1;
                    tmo_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = READ;
                    wrt_d   = 1'b1;
                    cmd_d   = RD_WORD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READ: begin
                state_d = WAIT2;
                cnt_d   = '0;
            end
            WAIT2: begin
                if (done) begin
                    state_d = STORE;
                    cap_d   = rd_data[11:0];
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = IDLE;
                    ptr_d     = ptr_q + 2'd1;
                    tmo_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STORE: begin
                case (ptr_q)
                    2'd0:    lft_d   = cap_q;
                    2'd1:    rght_d  = cap_q;
                    2'd2:    steer_d = cap_q;
                    default: batt_d  = cap_q;
                endcase
                ch_vld_d = 1'b1;
                ptr_d    = ptr_q + 2'd1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            cap_q     <= '0;
            lft_q     <= '0;
            rght_q    <= '0;
            steer_q   <= '0;
            batt_q    <= '0;
            wrt_q     <= 1'b0;
            cmd_q     <= '0;
            ch_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            lft_q     <= lft_d;
            rght_q    <= rght_d;
            steer_q   <= steer_d;
            batt_q    <= batt_d;
            wrt_q     <= wrt_d;
            cmd_q     <= cmd_d;
            ch_vld_q  <= ch_vld_d;
            busy_q    <= busy_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign steer_pot = steer_q;
    assign batt      = batt_q;
    assign ch_vld    = ch_vld_q;
    assign busy      = busy_q;
    assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_a2d_rr_sched.sv
// tb/tb_a2d_rr_sched.sv - scoreboard bench for a2d_rr_sched with a behavioural SPI master
module tb_a2d_rr_sched;

    localparam int GAP = 2;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt;
    logic [15:0] cmd;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        ch_vld, busy, tmo_err;

    a2d_rr_sched #(.GAP_CYCLES(GAP), .TMO_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt), .done(done), .rd_data(rd_data),
        .wrt(wrt), .cmd(cmd), .lft_ld(lft_ld), .rght_ld(rght_ld),
        .steer_pot(steer_pot), .batt(batt), .ch_vld(ch_vld), .busy(busy),
        .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int vld_cnt = 0;
    int wrt_cnt = 0;
    int tmo_cnt = 0;
    int exp_tmo = 0;
    int cyc = 0;
    int t_wrt = 0;
    int t_tmo = 0;
    int lat_cmd = 4;
    int lat_rd = 4;
    bit drop_cmd = 1'b0;
    bit wrt_prev = 1'b0;

    logic [15:0] exp_cmd[$];
    logic [47:0] exp_res[$];
    logic [15:0] rd_q[$];
    logic [11:0] m_reg[4];
    int          ptr_m = 0;

    function automatic logic [15:0] cmd_of(input int p);
        case (p)
            0:       cmd_of = 16'h0000;
            1:       cmd_of = 16'h2000;
            2:       cmd_of = 16'h2800;
            default: cmd_of = 16'h3000;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got unexpected event expected none", nm);
    endtask

    // SPI master model: answers each wrt with a done pulse after a set latency.
    initial begin
        bit is_rd;
        int lat;
        forever begin
            @(negedge clk);
            if (wrt === 1'b1) begin
                is_rd = (cmd == 16'hDA00);
                if (!(drop_cmd && !is_rd)) begin
                    lat = is_rd ? lat_rd : lat_cmd;
                    repeat (lat) @(negedge clk);
                    done = 1'b1;
                    if (is_rd) rd_data = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hFFFF;
                    else       rd_data = 16'h5555;
                    @(negedge clk);
                    done = 1'b0;
                    rd_data = 16'h0000;
                end
            end
        end
    end

    // Monitor: pops and compares expected commands, results and timeouts.
    initial begin
        logic [47:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (wrt === 1'b1) begin
                wrt_cnt++;
                t_wrt = cyc;
                if (wrt_prev) flag("wrt_back_to_back");
                if (exp_cmd.size() == 0) flag("cmd_unexpected");
                else chk("cmd", 32'(cmd), 32'(exp_cmd.pop_front()));
            end
            wrt_prev = (wrt === 1'b1);
            if (ch_vld === 1'b1) begin
                vld_cnt++;
                if (tmo_err === 1'b1) flag("vld_with_tmo");
                if (exp_res.size() == 0) flag("vld_unexpected");
                else begin
                    e = exp_res.pop_front();
                    chk("lft_ld",    32'(lft_ld),    32'(e[11:0]));
                    chk("rght_ld",   32'(rght_ld),   32'(e[23:12]));
                    chk("steer_pot", 32'(steer_pot), 32'(e[35:24]));
                    chk("batt",      32'(batt),      32'(e[47:36]));
                end
            end
            if (tmo_err === 1'b1) begin
                tmo_cnt++;
                t_tmo = cyc;
                if (exp_tmo == 0) flag("tmo_unexpected");
                else exp_tmo--;
            end
        end
    end

    task automatic pulse_nxt();
        @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
    endtask

    task automatic wait_vld(input int tgt);
        int n = 0;
        while (vld_cnt < tgt && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("vld_count", 32'(vld_cnt), 32'(tgt));
    endtask

    task automatic expect_conv(input logic [15:0] rd);
        exp_cmd.push_back(cmd_of(ptr_m));
        exp_cmd.push_back(16'hDA00);
        rd_q.push_back(rd);
        m_reg[ptr_m] = rd[11:0];
        exp_res.push_back({m_reg[3], m_reg[2], m_reg[1], m_reg[0]});
        ptr_m = (ptr_m + 1) % 4;
    endtask

    task automatic conv(input logic [15:0] rd);
        int tgt;
        tgt = vld_cnt + 1;
        expect_conv(rd);
        pulse_nxt();
        wait_vld(tgt);
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_lft"},   32'(lft_ld),    32'(m_reg[0]));
        chk({tag, "_rght"},  32'(rght_ld),   32'(m_reg[1]));
        chk({tag, "_steer"}, 32'(steer_pot), 32'(m_reg[2]));
        chk({tag, "_batt"},  32'(batt),      32'(m_reg[3]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int n;
        int t;
        for (int i = 0; i < 4; i++) m_reg[i] = 12'h000;

        // Power-on reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_wrt",     32'(wrt),     32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_ch_vld",  32'(ch_vld),  32'h0);
        chk("rst_tmo_err", 32'(tmo_err), 32'h0);
        chk("rst_cmd",     32'(cmd),     32'h0);
        check_regs("rst");

        // Single conversion
        lat_cmd = 4;
        lat_rd  = 4;
        conv(16'h0ABC);
        chk("single_lft", 32'(lft_ld), 32'h0ABC);

        // Reset held for two clocks while waiting on the read transaction
        lat_rd = 20;
        b = wrt_cnt;
        exp_cmd.push_back(cmd_of(ptr_m));
        exp_cmd.push_back(16'hDA00);
        rd_q.push_back(16'h0FFF);
        pulse_nxt();
        n = 0;
        while (wrt_cnt < b + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_wrt_pair", 32'(wrt_cnt), 32'(b + 2));
        repeat (3) @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) m_reg[i] = 12'h000;
        ptr_m = 0;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_wrt",  32'(wrt),  32'h0);
        check_regs("midrst");
        repeat (30) @(negedge clk);
        chk("midrst_stray_done_busy", 32'(busy), 32'h0);
        lat_rd = 4;

        // Round robin over all channels and wrap
        for (int i = 1; i <= 5; i++) conv(16'(i));
        chk("rr_lft",   32'(lft_ld),    32'h5);
        chk("rr_rght",  32'(rght_ld),   32'h2);
        chk("rr_steer", 32'(steer_pot), 32'h3);
        chk("rr_batt",  32'(batt),      32'h4);

        // nxt held high for 200 cycles with slow SPI: conversions start only when idle
        lat_cmd = 40;
        lat_rd  = 40;
        t = vld_cnt + 3;
        b = wrt_cnt;
        expect_conv(16'h0111);
        expect_conv(16'h0222);
        expect_conv(16'h0333);
        @(negedge clk);
        nxt = 1'b1;
        repeat (200) @(negedge clk);
        nxt = 1'b0;
        wait_vld(t);
        chk("drop_wrt_count", 32'(wrt_cnt), 32'(b + 6));
        chk("drop_busy", 32'(busy), 32'h0);
        check_regs("drop");

        // Timeout in the command transaction
        lat_cmd  = 4;
        lat_rd   = 4;
        drop_cmd = 1'b1;
        b = wrt_cnt;
        exp_cmd.push_back(cmd_of(ptr_m));
        exp_tmo++;
        ptr_m = (ptr_m + 1) % 4;
        t = tmo_cnt + 1;
        n = vld_cnt;
        pulse_nxt();
        begin
            int k = 0;
            while (tmo_cnt < t && k < 300) begin
                @(negedge clk);
                k++;
            end
        end
        chk("tmo_count", 32'(tmo_cnt), 32'(t));
        chk("tmo_delay", 32'(t_tmo - t_wrt), 32'(TMO + 1));
        chk("tmo_wrt_once", 32'(wrt_cnt), 32'(b + 1));
        chk("tmo_no_vld", 32'(vld_cnt), 32'(n));
        check_regs("tmo");
        drop_cmd = 1'b0;
        repeat (3) @(negedge clk);
        conv(16'h0456);
        chk("tmo_next_rght", 32'(rght_ld), 32'h456);

        // done in the very cycle the read timeout would fire
        lat_rd = TMO;
        t = tmo_cnt;
        conv(16'h0800);
        chk("edge_steer", 32'(steer_pot), 32'h800);
        chk("edge_no_tmo", 32'(tmo_cnt), 32'(t));

        repeat (5) @(negedge clk);
        chk("end_cmd_queue", 32'(exp_cmd.size()), 32'h0);
        chk("end_res_queue", 32'(exp_res.size()), 32'h0);
        chk("end_tmo_pending", 32'(exp_tmo), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
